// File: rtl/demux_pkg.sv
// Shared definitions for the demux scheduler: channel count, FSM encoding
// and index/one-hot conversion helpers.
package demux_pkg;

    localparam int NUM_CH = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARB    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_XFER   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        ARB    = S_ARB,
        SETTLE = S_SETTLE,
        XFER   = S_XFER,
        DRAIN  = S_DRAIN
    } state_t;

    function automatic logic [NUM_CH-1:0] idx2oh(input logic [1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [1:0] oh2idx(input logic [NUM_CH-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (oh[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/demux.sv
// Existing 1-to-4 demux: f is routed to q[{s1,s2}], other outputs are 0.
module demux (
    input  logic       f,
    input  logic       s1,
    input  logic       s2,
    output logic [3:0] q
);

    always_comb begin
        q            = '0;
        q[{s1, s2}]  = f;
    end

endmodule

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker: first requester found searching
// upward from ptr+1, wrapping.
module rr_arb4
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [1:0]        idx,
    output logic              any
);

    logic [1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        // 2-bit add wraps naturally; i = NUM_CH revisits ptr itself last
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = ptr + 2'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        gnt = any ? idx2oh(idx) : '0;
    end

endmodule

// File: rtl/demux_sched.sv
// Round-robin scheduler feeding one serial stream into the 1-to-4 demux:
// arbitrate, hold select for HOLD cycles, then forward up to BURST beats.
module demux_sched
    import demux_pkg::*;
#(
    parameter int HOLD  = 2,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] dest_req,
    input  logic              in_valid,
    input  logic              in_data,
    output logic              in_ready,
    output logic              s1,
    output logic              s2,
    output logic              f,
    output logic              strobe,
    output logic [NUM_CH-1:0] grant,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [1:0]        ptr;
    logic [1:0]        sel;
    logic [3:0]        scnt;
    logic [3:0]        bcnt;
    logic [NUM_CH-1:0] arb_gnt;
    logic [1:0]        arb_idx;
    logic              arb_any;
    logic              req_cur;
    logic              hs;
    logic              last_beat;

    rr_arb4 u_arb (
        .req (dest_req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign req_cur   = dest_req[sel];
    assign in_ready  = (state == XFER) && req_cur;
    assign hs        = in_ready && in_valid;
    assign last_beat = (bcnt == 4'(BURST - 1));
    assign {s1, s2}  = sel;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|dest_req) state_nxt = ARB;
            ARB:     state_nxt = arb_any ? SETTLE : IDLE;
            SETTLE:  if (scnt == 4'(HOLD - 1)) state_nxt = XFER;
            // a drop of dest_req wins over the final beat: in_ready is already low
            XFER:    if (!req_cur || (hs && last_beat)) state_nxt = DRAIN;
            DRAIN:   state_nxt = ARB;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= 2'd3;
            sel   <= '0;
            grant <= '0;
            scnt  <= '0;
            bcnt  <= '0;
        end else begin
            case (state)
                ARB: if (arb_any) begin
                    grant <= arb_gnt;
                    sel   <= arb_idx;
                    scnt  <= '0;
                end
                SETTLE: begin
                    if (scnt != 4'hf) scnt <= scnt + 4'd1;
                    bcnt <= '0;
                end
                XFER:    if (hs && bcnt != 4'hf) bcnt <= bcnt + 4'd1;
                DRAIN:   ptr <= sel;
                default: ;
            endcase
        end
    end

    // Beat is registered so it lands on q while select is still held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f      <= 1'b0;
            strobe <= 1'b0;
        end else begin
            f      <= hs & in_data;
            strobe <= hs;
        end
    end

endmodule

// File: tb/tb_demux_sched.sv
// Directed bench for demux_sched driving the demux; checks q, select, grant
// and strobe timing against hand-derived cycle numbers.
module tb_demux_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dest_req, dest_req2;
    logic       in_valid, in_valid2, in_data, in_data2;
    logic       in_ready, in_ready2, s1, s2, s1b, s2b, f, f2, strobe, strobe2, busy, busy2;
    logic [3:0] grant, grant2, q, q2;

    int checks = 0;
    int errors = 0;
    logic [31:0] pat = 32'hA5C3_96E1;

    always #5 clk = ~clk;

    demux_sched #(.HOLD(2), .BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .dest_req(dest_req), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .s1(s1), .s2(s2), .f(f), .strobe(strobe), .grant(grant), .busy(busy));
    demux u_dmx (.f(f), .s1(s1), .s2(s2), .q(q));

    demux_sched #(.HOLD(1), .BURST(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .dest_req(dest_req2), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .s1(s1b), .s2(s2b), .f(f2), .strobe(strobe2), .grant(grant2), .busy(busy2));
    demux u_dmx2 (.f(f2), .s1(s1b), .s2(s2b), .q(q2));

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; dest_req = '0; in_valid = 1'b0; in_data = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dest_req = '0; in_valid = 0; in_data = 0;
        dest_req2 = '0; in_valid2 = 0; in_data2 = 0;
        @(negedge clk);
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
        checks++; if ({s1, s2} !== 2'b00) begin errors++; $display("FAIL reset_sel got %b exp 00", {s1, s2}); end
        checks++; if ({f, strobe} !== 2'b00) begin errors++; $display("FAIL reset_f_strobe got %b exp 00", {f, strobe}); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (q !== 4'b0) begin errors++; $display("FAIL reset_q got %b exp 0000", q); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [4:0] bits;
        int nstb;
        logic exp_s, exp_r;
        bits = 5'b11101;  // beats 1,0,1,1 then 1
        do_reset();
        nstb = 0; in_valid = 1; in_data = bits[0]; dest_req = 4'b0001;
        for (int c = 1; c <= 13; c++) begin
            step();
            exp_s = (c >= 5 && c <= 8) || c == 13;
            exp_r = (c >= 4 && c <= 7) || c >= 12;
            checks++; if (strobe !== exp_s) begin errors++; $display("FAIL single_strobe c=%0d got %b exp %b", c, strobe, exp_s); end
            checks++; if (in_ready !== exp_r) begin errors++; $display("FAIL single_in_ready c=%0d got %b exp %b", c, in_ready, exp_r); end
            if (c >= 2) begin
                checks++;
                if ({s1, s2, grant} !== 6'b00_0001) begin errors++; $display("FAIL single_sel c=%0d got %b exp 000001", c, {s1, s2, grant}); end
            end
            if (strobe === 1'b1 && nstb < 5) begin
                checks++;
                if (q !== {3'b000, bits[nstb]}) begin errors++; $display("FAIL single_q beat=%0d got %b exp %b", nstb, q, {3'b000, bits[nstb]}); end
                nstb++;
                in_data = (nstb < 5) ? bits[nstb] : 1'b0;
            end
        end
        dest_req = '0; in_valid = 0;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b exp 0", busy); end
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant_kept got %b exp 0001", grant); end
    endtask

    task automatic test_round_robin();
        int nstb, last, exp_ch, exp_gap;
        logic [3:0] eg, eq;
        do_reset();
        nstb = 0; last = 0; in_valid = 1; in_data = pat[0]; dest_req = 4'hf;
        for (int c = 1; c <= 120 && nstb < 20; c++) begin
            step();
            if (strobe === 1'b1) begin
                exp_ch = (nstb / 4) % 4;
                eg = 4'b0001 << exp_ch;
                eq = 4'(pat[nstb]);
                eq = eq << exp_ch;
                checks++; if (grant !== eg) begin errors++; $display("FAIL rr_grant beat=%0d got %b exp %b", nstb, grant, eg); end
                checks++; if ({s1, s2} !== 2'(exp_ch)) begin errors++; $display("FAIL rr_sel beat=%0d got %b exp %0d", nstb, {s1, s2}, exp_ch); end
                checks++; if (q !== eq) begin errors++; $display("FAIL rr_q beat=%0d got %b exp %b", nstb, q, eq); end
                if (nstb > 0) begin
                    exp_gap = (nstb % 4 == 0) ? 5 : 1;
                    checks++; if (c - last != exp_gap) begin errors++; $display("FAIL rr_gap beat=%0d got %0d exp %0d", nstb, c - last, exp_gap); end
                end
                last = c; nstb++; in_data = pat[nstb];
            end
        end
        checks++; if (nstb != 20) begin errors++; $display("FAIL rr_count got %0d exp 20", nstb); end
        dest_req = '0; in_valid = 0;
        repeat (8) step();
    endtask

    task automatic test_drop();
        int nstb;
        logic [3:0] eq;
        do_reset();
        nstb = 0; in_valid = 1; in_data = pat[0]; dest_req = 4'b0100;
        for (int c = 1; c <= 30 && nstb < 2; c++) begin
            step();
            if (strobe === 1'b1) begin
                eq = 4'(pat[nstb]);
                eq = eq << 2;
                checks++; if (q !== eq) begin errors++; $display("FAIL drop_q beat=%0d got %b exp %b", nstb, q, eq); end
                nstb++; in_data = pat[nstb];
            end
        end
        checks++; if (nstb != 2) begin errors++; $display("FAIL drop_count got %0d exp 2", nstb); end
        dest_req = '0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drop_in_ready got %b exp 0", in_ready); end
        step();
        checks++; if ({strobe, busy} !== 2'b01) begin errors++; $display("FAIL drop_drain got strobe,busy=%b exp 01", {strobe, busy}); end
        step();
        checks++; if ({strobe, busy} !== 2'b01) begin errors++; $display("FAIL drop_arb got strobe,busy=%b exp 01", {strobe, busy}); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle got busy=%b exp 0", busy); end
        in_valid = 0;
    endtask

    task automatic test_valid_gap();
        int nstb, gap, last;
        logic [3:0] eq;
        do_reset();
        nstb = 0; gap = 0; last = 0; in_valid = 1; in_data = pat[4]; dest_req = 4'b0010;
        for (int c = 1; c <= 40 && nstb < 4; c++) begin
            step();
            if (gap > 0) begin
                checks++;
                if ({strobe, in_ready, s1, s2} !== 4'b0101) begin errors++; $display("FAIL gap_hold c=%0d got strobe,rdy,sel=%b exp 0101", c, {strobe, in_ready, s1, s2}); end
                gap--;
                if (gap == 0) in_valid = 1;
            end else if (strobe === 1'b1) begin
                eq = 4'(pat[nstb + 4]);
                eq = eq << 1;
                checks++; if (q !== eq) begin errors++; $display("FAIL gap_q beat=%0d got %b exp %b", nstb, q, eq); end
                if (nstb == 2) begin
                    checks++; if (c - last != 6) begin errors++; $display("FAIL gap_resume got %0d exp 6", c - last); end
                end
                last = c; nstb++; in_data = pat[nstb + 4];
                if (nstb == 2) begin gap = 5; in_valid = 0; end
            end
        end
        checks++; if (nstb != 4) begin errors++; $display("FAIL gap_count got %0d exp 4", nstb); end
        checks++; if ({in_ready, busy} !== 2'b01) begin errors++; $display("FAIL gap_drain got rdy,busy=%b exp 01", {in_ready, busy}); end
        dest_req = '0; in_valid = 0;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        int nstb;
        do_reset();
        nstb = 0; in_valid = 1; in_data = 1; dest_req = 4'b1000;
        for (int c = 1; c <= 30 && nstb < 2; c++) begin
            step();
            if (strobe === 1'b1) nstb++;
        end
        checks++; if (nstb != 2 || {s1, s2} !== 2'b11) begin errors++; $display("FAIL rstmid_setup got beats=%0d sel=%b exp 2 11", nstb, {s1, s2}); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, s1, s2, f, strobe, in_ready, busy} !== 10'b0) begin
            errors++; $display("FAIL rstmid_outputs got %b exp 0000000000", {grant, s1, s2, f, strobe, in_ready, busy});
        end
        dest_req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        checks++; if ({grant, s1, s2} !== 6'b0001_00) begin errors++; $display("FAIL rstmid_regrant got %b exp 000100", {grant, s1, s2}); end
        dest_req = '0; in_valid = 0;
        repeat (8) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_hold1_burst1();
        int nstb, last, exp_ch;
        logic [3:0] eg, eq;
        nstb = 0; last = 0; in_valid2 = 1; in_data2 = pat[8]; dest_req2 = 4'b0011;
        for (int c = 1; c <= 40 && nstb < 4; c++) begin
            step();
            if (strobe2 === 1'b1) begin
                exp_ch = nstb % 2;
                eg = 4'b0001 << exp_ch;
                eq = 4'(pat[nstb + 8]);
                eq = eq << exp_ch;
                checks++; if (grant2 !== eg) begin errors++; $display("FAIL h1_grant beat=%0d got %b exp %b", nstb, grant2, eg); end
                checks++; if (q2 !== eq) begin errors++; $display("FAIL h1_q beat=%0d got %b exp %b", nstb, q2, eq); end
                checks++;
                if (c - last != ((nstb == 0) ? 4 : 4)) begin errors++; $display("FAIL h1_timing beat=%0d got %0d exp 4", nstb, c - last); end
                last = c; nstb++; in_data2 = pat[nstb + 8];
            end
        end
        checks++; if (nstb != 4) begin errors++; $display("FAIL h1_count got %0d exp 4", nstb); end
        dest_req2 = '0; in_valid2 = 0;
        repeat (6) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_valid_gap();
        test_reset_mid();
        do_reset();
        test_hold1_burst1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
